// File: rtl/regset_wb_pkg.sv
// Shared definitions for the register-set write-back block: load funct3
// codes, arbiter source-select encoding and the starve counter width.
package regset_wb_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_ALU  = 2'd1,
      SRC_LSU  = 2'd2
   } src_e;

   localparam int STARVE_W = 4;

endpackage

// File: rtl/regset_wb_load_align.sv
// Load alignment and extension. Selects the byte/half addressed by
// byte_off_i from the raw aligned word and sign- or zero-extends it.
// Misaligned halfwords and undefined funct3 codes pass the raw word.
module regset_wb_load_align
   import regset_wb_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  byte_off_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        half_ok;

   // Pick the addressed byte/half, then extend according to funct3.
   always_comb begin
      byte_sel = data_i[7:0];
      case (byte_off_i)
         2'd0:    byte_sel = data_i[7:0];
         2'd1:    byte_sel = data_i[15:8];
         2'd2:    byte_sel = data_i[23:16];
         default: byte_sel = data_i[31:24];
      endcase
      half_sel = byte_off_i[1] ? data_i[31:16] : data_i[15:0];
      half_ok  = ~byte_off_i[0];

      data_o = data_i;
      case (funct3_i)
         F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
         F3_LBU:  data_o = {24'b0, byte_sel};
         F3_LH:   if (half_ok) data_o = {{16{half_sel[15]}}, half_sel};
         F3_LHU:  if (half_ok) data_o = {16'b0, half_sel};
         default: data_o = data_i;
      endcase
   end

endmodule

// File: rtl/regset_writeback.sv
// Write-side master for one core's 32x32 register set. Holds one ALU and
// one load result, arbitrates to a single registered write per cycle with
// a starvation guard, and tracks pending destination registers.
// Optional feature macro: REGSET_WB_BYPASS_EN adds fwd_valid/fwd_rd/fwd_data
// and moves the busy clear to the grant cycle.
module regset_writeback
   import regset_wb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter bit LSU_FIRST    = 1'b1
)
(
   input  logic        CLK,
   input  logic        RES,
   input  logic        alu_valid,
   output logic        alu_ready,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   input  logic        lsu_valid,
   output logic        lsu_ready,
   input  logic [4:0]  lsu_rd,
   input  logic [31:0] lsu_data,
   input  logic [2:0]  lsu_funct3,
   input  logic [1:0]  lsu_byte_off,
   input  logic        issue_valid,
   input  logic [4:0]  issue_rd,
   output logic [31:0] D,
   output logic [4:0]  A_D,
   output logic        write_enable,
   output logic [31:0] busy_mask
`ifdef REGSET_WB_BYPASS_EN
   ,
   output logic        fwd_valid,
   output logic [4:0]  fwd_rd,
   output logic [31:0] fwd_data
`endif
);

   localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_LIMIT);
   localparam logic [STARVE_W-1:0] STARVE_ONE = STARVE_W'(1);

   logic                alu_full_q, alu_full_d;
   logic [4:0]          alu_rd_q, alu_rd_d;
   logic [31:0]         alu_data_q, alu_data_d;
   logic                lsu_full_q, lsu_full_d;
   logic [4:0]          lsu_rd_q, lsu_rd_d;
   logic [31:0]         lsu_data_q, lsu_data_d;
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic                we_q, we_d;
   logic [4:0]          a_d_q, a_d_d;
   logic [31:0]         d_q, d_d;
   logic [31:0]         busy_q, busy_d;

   logic [31:0] lsu_aligned;
   src_e        grant;
   src_e        dflt_src, other_src;
   logic        dflt_full, other_full;
   logic        alu_take, lsu_take;
   logic [4:0]  commit_rd;
   logic [31:0] commit_data;
   logic        commit_wr;
   logic [31:0] set_vec, clr_vec;

   regset_wb_load_align u_align (
      .funct3_i   (lsu_funct3),
      .byte_off_i (lsu_byte_off),
      .data_i     (lsu_data),
      .data_o     (lsu_aligned)
   );

   // Arbiter: default source unless it has starved the other one long enough.
   always_comb begin
      dflt_src   = LSU_FIRST ? SRC_LSU : SRC_ALU;
      other_src  = LSU_FIRST ? SRC_ALU : SRC_LSU;
      dflt_full  = LSU_FIRST ? lsu_full_q : alu_full_q;
      other_full = LSU_FIRST ? alu_full_q : lsu_full_q;
      grant      = SRC_NONE;
      if (dflt_full && !(other_full && (starve_q == STARVE_LIM))) begin
         grant = dflt_src;
      end else if (other_full) begin
         grant = other_src;
      end
   end

   // Handshakes, holding-reg next state, starve counter and commit selection.
   always_comb begin
      alu_ready = RES & (~alu_full_q | (grant == SRC_ALU));
      lsu_ready = RES & (~lsu_full_q | (grant == SRC_LSU));
      alu_take  = alu_valid & alu_ready;
      lsu_take  = lsu_valid & lsu_ready;

      alu_full_d = alu_full_q;
      alu_rd_d   = alu_rd_q;
      alu_data_d = alu_data_q;
      if (alu_take) begin
         alu_full_d = 1'b1;
         alu_rd_d   = alu_rd;
         alu_data_d = alu_data;
      end else if (grant == SRC_ALU) begin
         alu_full_d = 1'b0;
      end

      lsu_full_d = lsu_full_q;
      lsu_rd_d   = lsu_rd_q;
      lsu_data_d = lsu_data_q;
      if (lsu_take) begin
         lsu_full_d = 1'b1;
         lsu_rd_d   = lsu_rd;
         lsu_data_d = lsu_aligned;
      end else if (grant == SRC_LSU) begin
         lsu_full_d = 1'b0;
      end

      starve_d = starve_q;
      if ((grant == other_src) || !other_full) begin
         starve_d = '0;
      end else if (grant == dflt_src) begin
         starve_d = starve_q + STARVE_ONE;
      end

      commit_rd   = (grant == SRC_LSU) ? lsu_rd_q   : alu_rd_q;
      commit_data = (grant == SRC_LSU) ? lsu_data_q : alu_data_q;
      commit_wr   = (grant != SRC_NONE) && (commit_rd != 5'd0);

      we_d  = commit_wr;
      a_d_d = a_d_q;
      d_d   = d_q;
      if (commit_wr) begin
         a_d_d = commit_rd;
         d_d   = commit_data;
      end
   end

   // Busy scoreboard: issue sets, commit clears, a same-cycle set wins.
   always_comb begin
      set_vec = '0;
      if (issue_valid && (issue_rd != 5'd0)) begin
         set_vec = 32'd1 << issue_rd;
      end
      clr_vec = '0;
`ifdef REGSET_WB_BYPASS_EN
      if (commit_wr) begin
         clr_vec = 32'd1 << commit_rd;
      end
`else
      if (we_q) begin
         clr_vec = 32'd1 << a_d_q;
      end
`endif
      busy_d    = (busy_q & ~clr_vec) | set_vec;
      busy_d[0] = 1'b0;
   end

   // State registers; reset drops both holding regs and any pending write.
   always_ff @(posedge CLK) begin
      if (!RES) begin
         alu_full_q <= 1'b0;
         alu_rd_q   <= '0;
         alu_data_q <= '0;
         lsu_full_q <= 1'b0;
         lsu_rd_q   <= '0;
         lsu_data_q <= '0;
         starve_q   <= '0;
         we_q       <= 1'b0;
         a_d_q      <= '0;
         d_q        <= '0;
         busy_q     <= '0;
      end else begin
         alu_full_q <= alu_full_d;
         alu_rd_q   <= alu_rd_d;
         alu_data_q <= alu_data_d;
         lsu_full_q <= lsu_full_d;
         lsu_rd_q   <= lsu_rd_d;
         lsu_data_q <= lsu_data_d;
         starve_q   <= starve_d;
         we_q       <= we_d;
         a_d_q      <= a_d_d;
         d_q        <= d_d;
         busy_q     <= busy_d;
      end
   end

   assign D            = d_q;
   assign A_D          = a_d_q;
   assign write_enable = we_q;
   assign busy_mask    = busy_q;

`ifdef REGSET_WB_BYPASS_EN
   assign fwd_valid = we_q & (a_d_q != 5'd0);
   assign fwd_rd    = a_d_q;
   assign fwd_data  = d_q;
`endif

endmodule

// File: tb/tb_regset_writeback.sv
// Bench for regset_writeback: directed stimulus pushes expected register
// writes into a queue; a negedge monitor pops and compares each write.
module tb_regset_writeback;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RES = 1'b0;
   logic        alu_valid = 1'b0;
   logic        alu_ready;
   logic [4:0]  alu_rd = '0;
   logic [31:0] alu_data = '0;
   logic        lsu_valid = 1'b0;
   logic        lsu_ready;
   logic [4:0]  lsu_rd = '0;
   logic [31:0] lsu_data = '0;
   logic [2:0]  lsu_funct3 = '0;
   logic [1:0]  lsu_byte_off = '0;
   logic        issue_valid = 1'b0;
   logic [4:0]  issue_rd = '0;
   logic [31:0] D;
   logic [4:0]  A_D;
   logic        write_enable;
   logic [31:0] busy_mask;
`ifdef REGSET_WB_BYPASS_EN
   logic        fwd_valid;
   logic [4:0]  fwd_rd;
   logic [31:0] fwd_data;
`endif

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks   = 0;
   int   errors   = 0;
   int   wr_count = 0;

   regset_writeback #(.STARVE_LIMIT(4), .LSU_FIRST(1'b1)) dut (
      .CLK          (CLK),
      .RES          (RES),
      .alu_valid    (alu_valid),
      .alu_ready    (alu_ready),
      .alu_rd       (alu_rd),
      .alu_data     (alu_data),
      .lsu_valid    (lsu_valid),
      .lsu_ready    (lsu_ready),
      .lsu_rd       (lsu_rd),
      .lsu_data     (lsu_data),
      .lsu_funct3   (lsu_funct3),
      .lsu_byte_off (lsu_byte_off),
      .issue_valid  (issue_valid),
      .issue_rd     (issue_rd),
      .D            (D),
      .A_D          (A_D),
      .write_enable (write_enable),
      .busy_mask    (busy_mask)
`ifdef REGSET_WB_BYPASS_EN
      ,
      .fwd_valid    (fwd_valid),
      .fwd_rd       (fwd_rd),
      .fwd_data     (fwd_data)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: every write must match the head of the expected queue.
   always @(negedge CLK) begin
      if (write_enable === 1'b1) begin
         wr_count++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: A_D=%0d D=%h, no write expected", A_D, D);
         end else begin
            mon_e = exp_q.pop_front();
            check("commit_rd", 32'(A_D), 32'(mon_e.rd));
            check("commit_data", D, mon_e.data);
`ifdef REGSET_WB_BYPASS_EN
            check("fwd_valid", 32'(fwd_valid), 32'd1);
            check("fwd_rd", 32'(fwd_rd), 32'(mon_e.rd));
            check("fwd_data", fwd_data, mon_e.data);
`endif
         end
      end
`ifdef REGSET_WB_BYPASS_EN
      else if (RES) begin
         check("fwd_valid_idle", 32'(fwd_valid), 32'd0);
      end
`endif
   end

   task automatic push_exp(input logic [4:0] rd, input logic [31:0] data);
      exp_t e;
      e.rd   = rd;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic alu_send(input logic [4:0] rd, input logic [31:0] data);
      int n = 0;
      @(negedge CLK);
      alu_valid = 1'b1;
      alu_rd    = rd;
      alu_data  = data;
      while (!alu_ready && n < 100) begin
         @(negedge CLK);
         n++;
      end
      if (!alu_ready) begin
         checks++;
         errors++;
         $display("FAIL alu_handshake_timeout: ready=%b after %0d cycles, required 1", alu_ready, n);
      end
      @(posedge CLK);
      #1 alu_valid = 1'b0;
   endtask

   task automatic lsu_send(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                           input logic [31:0] data);
      int n = 0;
      @(negedge CLK);
      lsu_valid    = 1'b1;
      lsu_rd       = rd;
      lsu_funct3   = f3;
      lsu_byte_off = off;
      lsu_data     = data;
      while (!lsu_ready && n < 100) begin
         @(negedge CLK);
         n++;
      end
      if (!lsu_ready) begin
         checks++;
         errors++;
         $display("FAIL lsu_handshake_timeout: ready=%b after %0d cycles, required 1", lsu_ready, n);
      end
      @(posedge CLK);
      #1 lsu_valid = 1'b0;
   endtask

   task automatic issue(input logic [4:0] rd);
      @(negedge CLK);
      issue_valid = 1'b1;
      issue_rd    = rd;
      @(negedge CLK);
      issue_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge CLK);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s_drain: %0d writes outstanding, required 0", name, exp_q.size());
         exp_q.delete();
      end
      repeat (3) @(negedge CLK);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int wc;
      int n;

      // 1: reset, then a single ALU write
      repeat (2) @(negedge CLK);
      check("rst_D", D, 32'h0);
      check("rst_A_D", 32'(A_D), 32'h0);
      check("rst_we", 32'(write_enable), 32'h0);
      check("rst_busy", busy_mask, 32'h0);
      check("rst_alu_ready", 32'(alu_ready), 32'h0);
      check("rst_lsu_ready", 32'(lsu_ready), 32'h0);
      RES = 1'b1;
      push_exp(5'd3, 32'hDEADBEEF);
      alu_send(5'd3, 32'hDEADBEEF);
      drain("t1");

      // 2: load alignment / extension
      push_exp(5'd7, 32'hFFFFFF80); lsu_send(5'd7, 3'b000, 2'd2, 32'h0080_0000);
      push_exp(5'd7, 32'h00000080); lsu_send(5'd7, 3'b100, 2'd2, 32'h0080_0000);
      push_exp(5'd7, 32'h00800000); lsu_send(5'd7, 3'b001, 2'd1, 32'h0080_0000);
      push_exp(5'd8, 32'hFFFF8001); lsu_send(5'd8, 3'b001, 2'd2, 32'h8001_0000);
      push_exp(5'd8, 32'h00008001); lsu_send(5'd8, 3'b101, 2'd2, 32'h8001_0000);
      push_exp(5'd8, 32'h8001ABCD); lsu_send(5'd8, 3'b101, 2'd3, 32'h8001_ABCD);
      push_exp(5'd4, 32'h12345678); lsu_send(5'd4, 3'b010, 2'd3, 32'h1234_5678);
      push_exp(5'd4, 32'hCAFEF00D); lsu_send(5'd4, 3'b011, 2'd0, 32'hCAFE_F00D);
      push_exp(5'd5, 32'h0000007F); lsu_send(5'd5, 3'b000, 2'd0, 32'h0000_007F);
      push_exp(5'd5, 32'h000000AB); lsu_send(5'd5, 3'b100, 2'd3, 32'hAB00_0000);
      drain("t2");

      // 3: both sources streaming: LSU x4, ALU, LSU x4, ALU, LSU x4, ALU
      for (int k = 0; k < 3; k++) begin
         for (int j = 0; j < 4; j++) begin
            push_exp(5'(10 + 4 * k + j), 32'h5000_0000 + 32'(4 * k + j));
         end
         push_exp(5'(1 + k), 32'hA000_0000 + 32'(k));
      end
      fork
         begin
            for (int i = 0; i < 12; i++) lsu_send(5'(10 + i), 3'b010, 2'd0, 32'h5000_0000 + 32'(i));
         end
         begin
            for (int i = 0; i < 3; i++) alu_send(5'(1 + i), 32'hA000_0000 + 32'(i));
         end
      join
      drain("t3");

      // 4: scoreboard set/clear, set wins on collision, rd=0 consumed silently
      issue(5'd12);
      check("busy_set_12", busy_mask, 32'h0000_1000);
      push_exp(5'd12, 32'h0000_1212);
      alu_send(5'd12, 32'h0000_1212);
      drain("t4a");
      check("busy_clr_12", busy_mask, 32'h0);
      issue(5'd9);
      check("busy_set_9", busy_mask, 32'h0000_0200);
      push_exp(5'd9, 32'h0000_0099);
      alu_send(5'd9, 32'h0000_0099);
`ifdef REGSET_WB_BYPASS_EN
      issue(5'd9);
`else
      n = 0;
      while (write_enable !== 1'b1 && n < 20) begin
         @(negedge CLK);
         n++;
      end
      check("t4_write_seen", 32'(write_enable), 32'd1);
      issue_valid = 1'b1;
      issue_rd    = 5'd9;
      @(negedge CLK);
      issue_valid = 1'b0;
`endif
      drain("t4b");
      check("busy_set_wins_9", busy_mask, 32'h0000_0200);
      wc = wr_count;
      alu_send(5'd0, 32'hFFFF_FFFF);
      repeat (5) @(negedge CLK);
      check("rd0_no_write", 32'(wr_count), 32'(wc));
      issue(5'd0);
      check("busy_rd0_ignored", busy_mask, 32'h0000_0200);

      // 5: reset with both holding regs full
      wc = wr_count;
      @(negedge CLK);
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h5555_5555;
      lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_funct3 = 3'b010; lsu_byte_off = 2'd0;
      lsu_data  = 32'h6666_6666;
      @(posedge CLK);
      #1;
      alu_valid = 1'b0;
      lsu_valid = 1'b0;
      @(negedge CLK);
      RES = 1'b0;
      #1;
      check("rstmid_alu_ready", 32'(alu_ready), 32'h0);
      check("rstmid_lsu_ready", 32'(lsu_ready), 32'h0);
      @(negedge CLK);
      check("rstmid_busy", busy_mask, 32'h0);
      check("rstmid_we", 32'(write_enable), 32'h0);
      @(negedge CLK);
      RES = 1'b1;
      repeat (6) @(negedge CLK);
      check("rstmid_no_write", 32'(wr_count), 32'(wc));

      // 6: random single-source traffic (forwarding ports checked by the monitor)
      for (int i = 0; i < 16; i++) begin
         logic [4:0]  r;
         logic [31:0] v;
         r = 5'($urandom_range(1, 31));
         v = $urandom;
         push_exp(r, v);
         if (i % 2 == 0) alu_send(r, v);
         else            lsu_send(r, 3'b010, 2'($urandom_range(0, 3)), v);
      end
      drain("t6");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
